// File: rtl/taxi_axil_pkg.sv
// rtl/taxi_axil_pkg.sv - AXI4-Lite shared response codes
package taxi_axil_pkg;

    typedef enum logic [1:0] {
        AXIL_RESP_OKAY   = 2'b00,
        AXIL_RESP_EXOKAY = 2'b01,
        AXIL_RESP_SLVERR = 2'b10,
        AXIL_RESP_DECERR = 2'b11
    } axil_resp_t;

endpackage

// File: rtl/taxi_axil_if.sv
// rtl/taxi_axil_if.sv - AXI4-Lite bus bundle with split write/read modports
interface taxi_axil_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int STRB_W   = DATA_W / 8,
    parameter int AWUSER_W = 1,
    parameter int WUSER_W  = 1,
    parameter int BUSER_W  = 1,
    parameter int ARUSER_W = 1,
    parameter int RUSER_W  = 1
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic [AWUSER_W-1:0] awuser;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [STRB_W-1:0]   wstrb;
    logic [WUSER_W-1:0]  wuser;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic [BUSER_W-1:0]  buser;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic [ARUSER_W-1:0] aruser;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic [RUSER_W-1:0]  ruser;
    logic                rvalid;
    logic                rready;

    modport wr_slv (
        input  awaddr, awprot, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wuser, wvalid,
        output wready,
        output bresp, buser, bvalid,
        input  bready
    );

    modport rd_slv (
        input  araddr, arprot, aruser, arvalid,
        output arready,
        output rdata, rresp, ruser, rvalid,
        input  rready
    );

    modport wr_mst (
        output awaddr, awprot, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wuser, wvalid,
        input  wready,
        input  bresp, buser, bvalid,
        output bready
    );

    modport rd_mst (
        output araddr, arprot, aruser, arvalid,
        input  arready,
        input  rdata, rresp, ruser, rvalid,
        output rready
    );

endinterface

// File: rtl/taxi_axil_reg_bank.sv
// rtl/taxi_axil_reg_bank.sv - AXI4-Lite register bank with byte-strobed writes
module taxi_axil_reg_bank
    import taxi_axil_pkg::*;
#(
    parameter int          REG_CNT   = 16,
    parameter logic [63:0] RESET_VAL = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    taxi_axil_if.wr_slv                         s_axil_wr,
    taxi_axil_if.rd_slv                         s_axil_rd,
    output logic [REG_CNT*s_axil_wr.DATA_W-1:0] reg_q,
    output logic [REG_CNT-1:0]                  reg_wr
);

    localparam int DATA_W   = s_axil_wr.DATA_W;
    localparam int ADDR_W   = s_axil_wr.ADDR_W;
    localparam int STRB_W   = s_axil_wr.STRB_W;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(REG_CNT);
    localparam int DEC_W    = ADDR_LSB + IDX_W;
    localparam bit CNT_OK   = (REG_CNT >= 2) && (REG_CNT <= 256) && ((REG_CNT & (REG_CNT - 1)) == 0);
    localparam bit BUS_OK   = ((DATA_W == 32) || (DATA_W == 64)) && (STRB_W * 8 == DATA_W)
                              && (s_axil_rd.DATA_W == DATA_W) && (s_axil_rd.ADDR_W == ADDR_W)
                              && (ADDR_W > DEC_W);

    if (!CNT_OK) begin : g_bad_reg_cnt
        $error("REG_CNT must be a power of two in 2..256");
    end
    if (!BUS_OK) begin : g_bad_bus
        $error("AXI-Lite buses must match, DATA_W 32 or 64, ADDR_W wider than decode");
    end

    logic [DATA_W-1:0]  r_regs [REG_CNT];
    logic               r_aw_held;
    logic [IDX_W-1:0]   r_aw_idx;
    logic               r_aw_ok;
    logic               r_w_held;
    logic [DATA_W-1:0]  r_w_data;
    logic [STRB_W-1:0]  r_w_strb;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic [REG_CNT-1:0] r_reg_wr;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;
    logic [1:0]         r_rresp;

    logic               w_awready;
    logic               w_wready;
    logic               w_arready;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;
    logic [IDX_W-1:0]   w_aw_idx;
    logic               w_aw_ok;
    logic [IDX_W-1:0]   w_ar_idx;
    logic               w_ar_ok;
    logic [IDX_W-1:0]   w_cm_idx;
    logic               w_cm_ok;
    logic [DATA_W-1:0]  w_cm_data;
    logic [STRB_W-1:0]  w_cm_strb;
    logic               w_commit;
    logic               w_unused;

    // Readies are gated by rst_n so they read 0 for the whole time reset is held.
    assign w_awready = rst_n && !r_aw_held && !r_bvalid;
    assign w_wready  = rst_n && !r_w_held && !r_bvalid;
    assign w_arready = rst_n && !r_rvalid;

    assign w_aw_hs = s_axil_wr.awvalid && w_awready;
    assign w_w_hs  = s_axil_wr.wvalid && w_wready;
    assign w_ar_hs = s_axil_rd.arvalid && w_arready;

    assign w_aw_idx = s_axil_wr.awaddr[ADDR_LSB +: IDX_W];
    assign w_aw_ok  = (s_axil_wr.awaddr >> DEC_W) == '0;
    assign w_ar_idx = s_axil_rd.araddr[ADDR_LSB +: IDX_W];
    assign w_ar_ok  = (s_axil_rd.araddr >> DEC_W) == '0;

    // A channel arriving this cycle bypasses its holder so same-cycle AW+W commit immediately.
    assign w_cm_idx  = r_aw_held ? r_aw_idx : w_aw_idx;
    assign w_cm_ok   = r_aw_held ? r_aw_ok  : w_aw_ok;
    assign w_cm_data = r_w_held  ? r_w_data : s_axil_wr.wdata;
    assign w_cm_strb = r_w_held  ? r_w_strb : s_axil_wr.wstrb;
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_ok   <= 1'b0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_reg_wr  <= '0;
            for (int i = 0; i < REG_CNT; i++) begin
                r_regs[i] <= RESET_VAL[DATA_W-1:0];
            end
        end else begin
            r_reg_wr <= '0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= w_aw_idx;
                r_aw_ok   <= w_aw_ok;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axil_wr.wdata;
                r_w_strb <= s_axil_wr.wstrb;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_cm_ok ? AXIL_RESP_OKAY : AXIL_RESP_DECERR;
                if (w_cm_ok) begin
                    r_reg_wr[w_cm_idx] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_cm_strb[b]) begin
                            r_regs[w_cm_idx][b*8 +: 8] <= w_cm_data[b*8 +: 8];
                        end
                    end
                end
            end
            if (r_bvalid && s_axil_wr.bready) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // Reads sample r_regs before this cycle's commit lands, so a colliding read sees old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_ar_ok ? r_regs[w_ar_idx] : '0;
                r_rresp  <= w_ar_ok ? AXIL_RESP_OKAY : AXIL_RESP_DECERR;
            end else if (r_rvalid && s_axil_rd.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axil_wr.awready = w_awready;
    assign s_axil_wr.wready  = w_wready;
    assign s_axil_wr.bvalid  = r_bvalid;
    assign s_axil_wr.bresp   = r_bresp;
    assign s_axil_wr.buser   = '0;
    assign s_axil_rd.arready = w_arready;
    assign s_axil_rd.rvalid  = r_rvalid;
    assign s_axil_rd.rdata   = r_rdata;
    assign s_axil_rd.rresp   = r_rresp;
    assign s_axil_rd.ruser   = '0;

    for (genvar i = 0; i < REG_CNT; i++) begin : g_reg_q
        assign reg_q[i*DATA_W +: DATA_W] = r_regs[i];
    end
    assign reg_wr = r_reg_wr;

    assign w_unused = ^{s_axil_wr.awprot, s_axil_wr.awuser, s_axil_wr.wuser,
                        s_axil_rd.arprot, s_axil_rd.aruser};

endmodule

// File: doc/taxi_axil_reg_bank.md
TAXI_AXIL_REG_BANK -- requirements
Module: taxi_axil_reg_bank

Interface
REQ-001 SHALL have parameter REG_CNT, default 16, meaning number of DATA_W-bit registers (power of two, 2..256).
REQ-002 SHALL have parameter RESET_VAL, default 0, meaning the value loaded into every register on reset.
REQ-003 SHALL take DATA_W, ADDR_W, STRB_W from the attached taxi_axil_if instances; DATA_W 32 or 64, STRB_W = DATA_W/8.
REQ-004 SHALL have port clk  input  1  single clock; all logic is in this one clock domain.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port s_axil_wr  taxi_axil_if write-slave modport  -  AXI4-Lite write responder (AW, W, B).
REQ-007 SHALL have port s_axil_rd  taxi_axil_if read-slave modport  -  AXI4-Lite read responder (AR, R).
REQ-008 SHALL have port reg_q  output  REG_CNT*DATA_W  current register contents, register i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port reg_wr  output  REG_CNT  one-cycle pulse per register on each committed write to it.

Function
REQ-010 Decode SHALL use idx = addr[ADDR_LSB +: log2(REG_CNT)], ADDR_LSB = log2(STRB_W); low ADDR_LSB bits ignored.
REQ-011 Address >= REG_CNT*STRB_W SHALL give resp DECERR (2'b11): no write, rdata 0; all other accesses resp OKAY (2'b00).
REQ-012 AW and W SHALL be accepted independently, each captured into a holding register, in either order or the same cycle.
REQ-013 awready SHALL be 1 only when no AW held and no B pending; wready 1 only when no W held and no B pending.
REQ-014 Write commit SHALL occur the cycle after both AW and W are held; each byte lane updates only where wstrb bit is 1.
REQ-015 On commit, bvalid SHALL assert and reg_wr[idx] pulse for one cycle; wstrb all zero still commits OKAY and pulses reg_wr, data unchanged.
REQ-016 Latency: AW and W handshakes both in cycle N -> register and reg_q updated, bvalid high, in N+1.
REQ-017 bvalid, bresp SHALL hold stable until bready; holders cleared at B handshake, awready/wready return to 1 the next cycle.
REQ-018 Read: arready SHALL be 1 when no R pending; AR handshake in cycle N -> rvalid, rdata, rresp valid in N+1.
REQ-019 rvalid, rdata, rresp SHALL hold stable until rready; at most one read and one write outstanding.
REQ-020 Read capture coinciding with write commit to the same register SHALL return the pre-write value.
REQ-021 buser and ruser SHALL be driven 0; awuser, wuser, aruser, awprot, arprot ignored.
REQ-022 reg_q SHALL be driven directly from the register flops, no extra pipeline stage.

Reset
REQ-023 While rst_n low: awready, wready, arready, bvalid, rvalid 0; bresp, rresp, rdata 0; reg_wr 0; holders empty.
REQ-024 While rst_n low every register SHALL equal RESET_VAL; awready, wready, arready 1 in first cycle after release.
REQ-025 Reset mid-transaction SHALL discard held AW/W and pending B/R with no commit and no response after release.

Structure
REQ-026 Response codes OKAY, EXOKAY, SLVERR, DECERR SHALL live in shared package taxi_axil_pkg as a 2-bit typedef.
REQ-027 Decode width, ADDR_LSB and REG_CNT checks SHALL be localparams in the module; REG_CNT not a power of two fails elaboration.
REQ-028 No sub-module; write and read paths are two independent always_ff blocks in one file.

Verification
REQ-029 AW 0x04 and W 0xDEADBEEF wstrb 0xF same cycle, bready 1 -> bvalid next cycle OKAY, reg_wr[1] pulses, read 0x04 returns 0xDEADBEEF.
REQ-030 W 0x11223344 wstrb 0x3 then AW 0x08 three cycles later -> reg 2 = 0x00003344 from reset 0, single B OKAY.
REQ-031 Write 0x40 with REG_CNT 16 -> bresp DECERR, no reg_wr; read 0x40 -> rdata 0, rresp DECERR.
REQ-032 bready held 0 for 5 cycles -> bvalid and bresp stable, awready and wready 0 throughout; second AW accepted only after B.
REQ-033 Write 0x0C commit and AR 0x0C accepted same cycle (reg 3 = 0x5) with new data 0xA -> rdata 0x5, subsequent read 0xA.
REQ-034 rst_n pulsed low while AW held and W not yet sent -> no B after release, all registers RESET_VAL, readies 1.
